myo_spi_slave: RTL

SPI responder for the myocontrol SPI link: the motor-board end of the `miso`/`mosi`/`sck`/`ss_n` bus that the myocontrol master drives from `GPIO_0`. It runs in the FPGA system clock domain and oversamples the SPI pins. Each received word is delivered on a one-cycle valid strobe. Reply words come from a valid/ready source and are shifted out on `miso`. It serves as a bench responder for the master and as the slave core for board emulation.

---
 rtl/myo_spi_pkg.sv | 22 ++
 rtl/myo_spi_sync.sv | 42 ++++
 rtl/myo_spi_slave.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg
//   Shared definitions for the myocontrol SPI responder: FSM state
//   encoding, default word width, the fill word used on tx underrun and
//   a saturating 4-bit increment for the in-frame word index.
//   Related build option: MYO_SPI_SLAVE_ECHO_EN (see myo_spi_slave).
package myo_spi_pkg;

    typedef enum logic [1:0] {
        MYO_SPI_IDLE  = 2'd0,
        MYO_SPI_LOAD  = 2'd1,
        MYO_SPI_SHIFT = 2'd2
    } myo_spi_state_e;

    localparam int MYO_SPI_WIDTH_DEFAULT = 16;
    localparam int MYO_SPI_FILL_WORD     = 0;

    // Word index within a frame sticks at 15 once reached.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/myo_spi_sync.sv
// myo_spi_sync
//   Multi-flop synchronizer for one asynchronous SPI pin, followed by one
//   extra flop so edges can be found by comparing against the previous
//   synchronized value.
//   Ports:
//     clk, rst_n : system clock, synchronous active-low reset
//     din        : asynchronous pin
//     level      : synchronized level (SYNC_STAGES cycles behind the pin)
//     rise, fall : single-cycle pulses when level changes
//   SYNC_STAGES must be at least 2.
module myo_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic                   prev_reg;

    // Everything clears to 0, including the ss_n chain. Because a fall
    // needs a previous high, a frame already running across reset (ss_n
    // held low) is never picked up; the master must release ss_n first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg <= '0;
            prev_reg  <= 1'b0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], din};
            prev_reg  <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign level = stage_reg[SYNC_STAGES-1];
    assign rise  = (level ^ prev_reg) & level;
    assign fall  = (level ^ prev_reg) & ~level;

endmodule

// File: rtl/myo_spi_slave.sv
// myo_spi_slave
//   SPI mode-0 responder for the myocontrol link, oversampling sck, ss_n
//   and mosi in the clk domain. Received words come out on a one-cycle
//   rx_valid strobe; reply words are pulled from a valid/ready source.
//   Ports:
//     clk, rst_n             : system clock, synchronous active-low reset
//     sck, ss_n, mosi        : SPI pins from the master (asynchronous)
//     miso, miso_oe          : reply data and pad enable
//     rx_data/rx_valid/rx_idx: received word, strobe, index within frame
//     tx_data/tx_valid       : next reply word source
//     tx_ready               : tx_data consumed this cycle
//     tx_underrun            : fill word loaded because tx_valid was low
//     frame_done / frame_err : ss_n rose on / off a word boundary
//   Build option MYO_SPI_SLAVE_ECHO_EN: fill word is the last rx_data
//   (echo); otherwise the fill word is all zeros.
module myo_spi_slave
    import myo_spi_pkg::*;
#(
    parameter int WIDTH       = MYO_SPI_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [3:0]       rx_idx,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_done,
    output logic             frame_err
);

    localparam logic [1:0] IDLE  = MYO_SPI_IDLE;
    localparam logic [1:0] LOAD  = MYO_SPI_LOAD;
    localparam logic [1:0] SHIFT = MYO_SPI_SHIFT;
    localparam int         CNT_W = $clog2(WIDTH + 1);

    // Synchronized pins
    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    myo_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    myo_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .din(ss_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );
    myo_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only edges of sck/ss_n and the level of mosi drive the datapath.
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_level, mosi_rise, mosi_fall};

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] tx_shift_reg;
    logic [WIDTH-1:0] rx_shift_reg;
    logic [WIDTH-1:0] rx_data_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [3:0]       word_cnt_reg;
    logic [3:0]       rx_idx_reg;
    logic             reload_reg;
    logic             miso_reg;
    logic             rx_valid_reg;
    logic             frame_done_reg;
    logic             frame_err_reg;

    logic [WIDTH-1:0] fill_word;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] rx_next;
    logic             load_now;

`ifdef MYO_SPI_SLAVE_ECHO_EN
    assign fill_word = rx_data_reg;
`else
    assign fill_word = WIDTH'(MYO_SPI_FILL_WORD);
`endif

    assign load_word = tx_valid ? tx_data : fill_word;
    assign rx_next   = {rx_shift_reg[WIDTH-2:0], mosi_level};

    // A tx word is taken either in LOAD or on the first sck fall after a
    // completed word. An ss_n rise in the same cycle cancels the load.
    always_comb begin
        load_now = 1'b0;
        if (rst_n) begin
            if (state_reg == LOAD && !ss_rise) begin
                load_now = 1'b1;
            end else if (state_reg == SHIFT && !ss_rise && sck_fall && reload_reg) begin
                load_now = 1'b1;
            end
        end
    end

    assign tx_ready    = load_now & tx_valid;
    assign tx_underrun = load_now & ~tx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            tx_shift_reg   <= '0;
            rx_shift_reg   <= '0;
            rx_data_reg    <= '0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            rx_idx_reg     <= '0;
            reload_reg     <= 1'b0;
            miso_reg       <= 1'b0;
            rx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (ss_rise) begin
                        // Only reachable if the master violates the
                        // setup time; treat as an empty frame.
                        frame_done_reg <= 1'b1;
                        word_cnt_reg   <= '0;
                        state_reg      <= IDLE;
                    end else begin
                        tx_shift_reg <= load_word;
                        miso_reg     <= load_word[WIDTH-1];
                        bit_cnt_reg  <= '0;
                        reload_reg   <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        if (bit_cnt_reg == '0) begin
                            frame_done_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                        word_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        reload_reg   <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (sck_rise) begin
                        rx_shift_reg <= rx_next;
                        if (bit_cnt_reg == CNT_W'(WIDTH - 1)) begin
                            rx_data_reg  <= rx_next;
                            rx_valid_reg <= 1'b1;
                            rx_idx_reg   <= word_cnt_reg;
                            word_cnt_reg <= sat_inc4(word_cnt_reg);
                            bit_cnt_reg  <= '0;
                            reload_reg   <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        if (reload_reg) begin
                            tx_shift_reg <= load_word;
                            miso_reg     <= load_word[WIDTH-1];
                            reload_reg   <= 1'b0;
                        end else begin
                            tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
                            miso_reg     <= tx_shift_reg[WIDTH-2];
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Any non-IDLE state implies the synchronized ss_n went low.
    assign miso_oe    = (state_reg != IDLE) & ~ss_level;
    assign miso       = miso_reg;
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign rx_idx     = rx_idx_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;

endmodule
